svnet_pool_window: RTL and testbench
====================================

Name: svnet_pool_window

Overview:
Streaming window gatherer that sits directly upstream of the tree-max reducer in the max-pool layer.
- Accepts one feature-map pixel per valid cycle, in raster order.
- Buffers POOL-1 previous rows.
- Emits a packed POOL*POOL window vector at every stride position, in the exact `[COUNT-1:0][WIDTH-1:0]` layout the reducer consumes.
- Valid-only streaming: no backpressure, like the rest of the datapath.

Parameters:
WIDTH, 8, pixel bit width (two's complement; passed through untouched)
IMG_W, 8, feature-map width in pixels (>= POOL)
IMG_H, 8, feature-map height in pixels (>= POOL)
POOL, 2, square window edge; output COUNT = POOL*POOL
STRIDE, 2, horizontal and vertical step between emitted windows (1..POOL)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
i_data_valid  input  1  pixel strobe; state advances only when high
i_data  input  WIDTH  pixel value
o_data_valid  output  1  window strobe, registered
o_data  output  POOL*POOL*WIDTH  packed `[POOL*POOL-1:0][WIDTH-1:0]`; element r*POOL+c = window row r, column c; element 0 = top-left (oldest)

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - o_data_valid=0, o_data=0.
  - col, row, col_phase and row_phase counters = 0.
  - Line-buffer and window-register contents are not reset.
- Counters, updated on each accepted pixel:
  - col increments and wraps IMG_W-1 -> 0.
  - On that wrap, row increments and wraps IMG_H-1 -> 0, which starts a new frame.
- Stride phase counters replace any modulo operation:
  - col_phase resets to 0 at col=POOL-1, otherwise increments and wraps at STRIDE.
  - row_phase does the same against row, stepping once per row wrap.
- Line buffer:
  - POOL-1 rows of IMG_W entries, addressed by col.
  - On an accepted pixel, read the column stack and write the new pixel with a read-before-write shift.
  - The window register (POOL x POOL) shifts left one column and loads the new column: POOL-1 buffered rows plus the incoming pixel as the bottom row.
- Emit condition, evaluated on the accepted pixel:
  - Requires col >= POOL-1, row >= POOL-1, col_phase == 0 and row_phase == 0.
  - o_data_valid goes high the next cycle for exactly one cycle, with o_data = updated window.
  - Latency is 1 cycle from the completing pixel.
- Windows per frame: ((IMG_W-POOL)/STRIDE+1) * ((IMG_H-POOL)/STRIDE+1). Trailing columns/rows not covered by a full window are dropped.
- Input gaps: any number of idle cycles between pixels is legal. o_data holds its last value; o_data_valid=0.
- Frame boundary: the first pixel of frame N+1 may arrive the cycle after the last pixel of frame N. The final window of frame N is still emitted, and no window spans frames because the row gate restarts at 0.
- Reset mid-frame: counters return to 0 and the next pixel is treated as (0,0). Stale buffer contents are never emitted, because emission requires POOL-1 fresh rows.
- Arithmetic: counters are $clog2(max+1) bits. No arithmetic on pixel data.

Optional Feature:
Macro: SVNET_POOL_WINDOW_LAST_EN.
- Defined: adds output o_last (1 bit, reset 0), high together with o_data_valid on the final window of each frame (bottom-right stride position) and low otherwise. Downstream uses it to delimit frames.
- Undefined: the port does not exist and no extra logic is generated.

Decomposition:
- Package svnet_pool_pkg holds:
  - function pool_count(POOL) = POOL*POOL;
  - function pool_windows(IMG, POOL, STRIDE);
  - a localparam-style helper for counter widths.
- One natural sub-module, svnet_line_buffer:
  - parameters WIDTH, DEPTH=IMG_W, ROWS=POOL-1;
  - i_valid, i_addr, i_data in; column stack out combinationally from registered storage.
  - Instantiated once; for POOL=1 it is generated away.
- Output is connected by the parent directly to the tree-max instance with COUNT=POOL*POOL.

Test Plan:
- 4x4 image, POOL=2, STRIDE=2, pixels 0..15 back-to-back -> 4 windows, each listed as elements [0..3]: {0,1,4,5}, {2,3,6,7}, {8,9,12,13}, {10,11,14,15}. Each is valid 1 cycle after pixels 5, 7, 13, 15 respectively.
- 3x3 image, POOL=2, STRIDE=1, pixels 0..8 -> {0,1,3,4}, {1,2,4,5}, {3,4,6,7}, {4,5,7,8}.
- 4x4 image, POOL=2, STRIDE=2, random 0-3 idle cycles between pixels -> identical window values and order to the first scenario; o_data_valid never high on an idle-following cycle without a completing pixel.
- Two frames back-to-back (pixels 0..15, then 100..115) -> 8 windows; the fifth is {100,101,104,105}; with LAST_EN, o_last high on windows 4 and 8 only.
- Assert rst_n after pixel 9 of a frame, release, then stream a full frame 50..65 -> first window {50,51,54,55}; no window emitted before it.
- WIDTH=8, pixels 0x80..0x8F -> window bit patterns preserved exactly (0x80,0x81,0x84,0x85 first); downstream tree max yields 0x85.

Source files
------------

// File: rtl/svnet_pool_pkg.sv
// Shared helpers for the max-pool window gatherer: window geometry and counter widths.
package svnet_pool_pkg;

  function automatic int pool_count(input int pool);
    return pool * pool;
  endfunction

  // Window positions along one dimension. Trailing pixels that do not fill a window are dropped.
  function automatic int pool_windows(input int img, input int pool, input int stride);
    return (img - pool) / stride + 1;
  endfunction

  // Width of a counter that must hold 0..max_val. It is never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/svnet_line_buffer.sv
// Row history for the window gatherer: ROWS stacked rows of DEPTH pixels, addressed by column.
// Row 0 of the column stack is the oldest row. A write shifts the column up by one and adds i_data at the bottom.
module svnet_line_buffer
  import svnet_pool_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int ROWS  = 1,
  localparam int AW   = cnt_w(DEPTH - 1)
) (
  input  logic                       clk,
  input  logic                       i_valid,
  input  logic [AW-1:0]              i_addr,
  input  logic [WIDTH-1:0]           i_data,
  output logic [ROWS-1:0][WIDTH-1:0] o_col
);

  logic [WIDTH-1:0] r_mem [ROWS][DEPTH];

  // Every row reads its old value before the write, so one column shifts up as a unit.
  always_ff @(posedge clk) begin
    if (i_valid) begin
      for (int r = 0; r < ROWS - 1; r++) begin
        r_mem[r][i_addr] <= r_mem[r+1][i_addr];
      end
      r_mem[ROWS-1][i_addr] <= i_data;
    end
  end

  always_comb begin
    o_col = '0;
    for (int r = 0; r < ROWS; r++) begin
      o_col[r] = r_mem[r][i_addr];
    end
  end

endmodule

// File: rtl/svnet_pool_window.sv
// Streaming POOLxPOOL window gatherer that feeds the tree-max reducer. It takes raster-order pixels and emits a window at each stride position.
// Optional o_last frame delimiter: define SVNET_POOL_WINDOW_LAST_EN.
module svnet_pool_window
  import svnet_pool_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int POOL   = 2,
  parameter int STRIDE = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_data_valid,
  input  logic [WIDTH-1:0]                 i_data,
  output logic                             o_data_valid,
  output logic [POOL*POOL-1:0][WIDTH-1:0]  o_data
`ifdef SVNET_POOL_WINDOW_LAST_EN
  ,
  output logic                             o_last
`endif
);

  localparam int COUNT = pool_count(POOL);
  localparam int COL_W = cnt_w(IMG_W - 1);
  localparam int ROW_W = cnt_w(IMG_H - 1);
  localparam int PH_W  = cnt_w(STRIDE - 1);

  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] GATE_COL = COL_W'(POOL - 1);
  localparam logic [ROW_W-1:0] GATE_ROW = ROW_W'(POOL - 1);
  localparam logic [PH_W-1:0]  PH_MAX   = PH_W'(STRIDE - 1);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [PH_W-1:0]  r_col_phase;
  logic [PH_W-1:0]  r_row_phase;
  logic [POOL-1:0][POOL-1:0][WIDTH-1:0] r_win;
  logic                         r_valid;
  logic [COUNT-1:0][WIDTH-1:0]  r_data;

  logic [PH_W-1:0]  w_col_ph_cur;
  logic [PH_W-1:0]  w_row_ph_cur;
  logic [PH_W-1:0]  w_col_ph_next;
  logic [PH_W-1:0]  w_row_ph_next;
  logic             w_emit;
  logic [POOL-1:0][WIDTH-1:0]            w_stack;
  logic [POOL-1:0][POOL-1:0][WIDTH-1:0]  w_win_next;
  logic [COUNT-1:0][WIDTH-1:0]           w_flat;

  // The first window column or row forces phase 0. Stride positions are then counted from there without a modulo.
  assign w_col_ph_cur  = (r_col == GATE_COL) ? '0 : r_col_phase;
  assign w_row_ph_cur  = (r_row == GATE_ROW) ? '0 : r_row_phase;
  assign w_col_ph_next = (w_col_ph_cur == PH_MAX) ? '0 : w_col_ph_cur + PH_W'(1);
  assign w_row_ph_next = (w_row_ph_cur == PH_MAX) ? '0 : w_row_ph_cur + PH_W'(1);

  assign w_emit = i_data_valid && (r_col >= GATE_COL) && (r_row >= GATE_ROW) &&
                  (w_col_ph_cur == '0) && (w_row_ph_cur == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col       <= '0;
      r_row       <= '0;
      r_col_phase <= '0;
      r_row_phase <= '0;
    end else if (i_data_valid) begin
      r_col_phase <= w_col_ph_next;
      if (r_col == COL_MAX) begin
        r_col       <= '0;
        r_row_phase <= w_row_ph_next;
        r_row       <= (r_row == ROW_MAX) ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  assign w_stack[POOL-1] = i_data;

  generate
    if (POOL > 1) begin : g_lb
      logic [POOL-2:0][WIDTH-1:0] w_lb_col;

      svnet_line_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (IMG_W),
        .ROWS  (POOL - 1)
      ) u_line_buffer (
        .clk     (clk),
        .i_valid (i_data_valid),
        .i_addr  (r_col),
        .i_data  (i_data),
        .o_col   (w_lb_col)
      );

      assign w_stack[POOL-2:0] = w_lb_col;
    end
  endgenerate

  always_comb begin
    w_win_next = r_win;
    for (int r = 0; r < POOL; r++) begin
      for (int c = 0; c < POOL - 1; c++) begin
        w_win_next[r][c] = r_win[r][c+1];
      end
      w_win_next[r][POOL-1] = w_stack[r];
    end
  end

  always_comb begin
    w_flat = '0;
    for (int r = 0; r < POOL; r++) begin
      for (int c = 0; c < POOL; c++) begin
        w_flat[r*POOL+c] = w_win_next[r][c];
      end
    end
  end

  // Window contents are only emitted after POOL-1 fresh rows, so they need no reset.
  always_ff @(posedge clk) begin
    if (i_data_valid) begin
      r_win <= w_win_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= w_emit;
      if (w_emit) begin
        r_data <= w_flat;
      end
    end
  end

  assign o_data_valid = r_valid;
  assign o_data       = r_data;

`ifdef SVNET_POOL_WINDOW_LAST_EN
  localparam logic [COL_W-1:0] LAST_COL =
    COL_W'(POOL - 1 + (pool_windows(IMG_W, POOL, STRIDE) - 1) * STRIDE);
  localparam logic [ROW_W-1:0] LAST_ROW =
    ROW_W'(POOL - 1 + (pool_windows(IMG_H, POOL, STRIDE) - 1) * STRIDE);

  logic r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b0;
    end else begin
      r_last <= w_emit && (r_col == LAST_COL) && (r_row == LAST_ROW);
    end
  end

  assign o_last = r_last;
`endif

endmodule

// File: tb/tb_svnet_pool_window.sv
// Directed bench for svnet_pool_window. Instance A is 4x4 with stride 2, and instance B is 3x3 with stride 1. Both use POOL=2.
module tb_svnet_pool_window;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_valid, b_valid;
  logic [7:0]  a_data, b_data;
  logic        a_ovalid, b_ovalid;
  logic [31:0] a_odata, b_odata;
`ifdef SVNET_POOL_WINDOW_LAST_EN
  logic        a_last, b_last;
`endif

  svnet_pool_window #(.WIDTH(8), .IMG_W(4), .IMG_H(4), .POOL(2), .STRIDE(2)) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_data_valid (a_valid),
    .i_data       (a_data),
    .o_data_valid (a_ovalid),
    .o_data       (a_odata)
`ifdef SVNET_POOL_WINDOW_LAST_EN
    ,
    .o_last       (a_last)
`endif
  );

  svnet_pool_window #(.WIDTH(8), .IMG_W(3), .IMG_H(3), .POOL(2), .STRIDE(1)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_data_valid (b_valid),
    .i_data       (b_data),
    .o_data_valid (b_ovalid),
    .o_data       (b_odata)
`ifdef SVNET_POOL_WINDOW_LAST_EN
    ,
    .o_last       (b_last)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---- driver ----
  int a_cnt = 0, b_cnt = 0;
  bit a_acc = 0, b_acc = 0;

  task automatic a_px(input logic [7:0] px);
    a_valid = 1'b1;
    a_data  = px;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    a_cnt++;
    a_acc = 1'b1;
  endtask

  task automatic a_idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      a_acc = 1'b0;
    end
  endtask

  task automatic b_px(input logic [7:0] px);
    b_valid = 1'b1;
    b_data  = px;
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    b_cnt++;
    b_acc = 1'b1;
  endtask

  // ---- monitor: window value, completing pixel index (-1 if no pixel was accepted), last flag ----
  logic [31:0] got_q[$];
  int          got_idx_q[$];
  bit          got_last_q[$];

  always @(negedge clk) begin
    if (a_ovalid) begin
      got_q.push_back(a_odata);
      got_idx_q.push_back(a_acc ? a_cnt - 1 : -1);
`ifdef SVNET_POOL_WINDOW_LAST_EN
      got_last_q.push_back(a_last);
`else
      got_last_q.push_back(1'b0);
`endif
    end
    if (b_ovalid) begin
      got_q.push_back(b_odata);
      got_idx_q.push_back(b_acc ? b_cnt - 1 : -1);
`ifdef SVNET_POOL_WINDOW_LAST_EN
      got_last_q.push_back(b_last);
`else
      got_last_q.push_back(1'b0);
`endif
    end
  end

  // ---- scoreboard ----
  logic [31:0] exp_q[$];
  int          exp_idx_q[$];
  bit          exp_last_q[$];

  function automatic logic [31:0] win(input logic [7:0] e0, input logic [7:0] e1,
                                      input logic [7:0] e2, input logic [7:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic expect_win(input logic [31:0] w, input int idx, input bit last);
    exp_q.push_back(w);
    exp_idx_q.push_back(idx);
    exp_last_q.push_back(last);
  endtask

  task automatic clear_all();
    got_q.delete(); got_idx_q.delete(); got_last_q.delete();
    exp_q.delete(); exp_idx_q.delete(); exp_last_q.delete();
  endtask

  task automatic score(input string tag);
    int n;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = 0;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [31:0] g, e;
      int gi, ei;
      bit gl, el;
      g  = got_q.pop_front();      e  = exp_q.pop_front();
      gi = got_idx_q.pop_front();  ei = exp_idx_q.pop_front();
      gl = got_last_q.pop_front(); el = exp_last_q.pop_front();
      check($sformatf("%s_w%0d_data", tag, n), g, e);
      check($sformatf("%s_w%0d_idx", tag, n), 32'(gi), 32'(ei));
`ifdef SVNET_POOL_WINDOW_LAST_EN
      check($sformatf("%s_w%0d_last", tag, n), {31'd0, gl}, {31'd0, el});
`else
      if (gl != el) $display("unexpected last flag without LAST_EN");
`endif
      n++;
    end
    clear_all();
  endtask

  // Standard 4x4 stride-2 expectations; base is the first pixel value, off the pixel-index offset.
  task automatic expect_frame_a(input logic [7:0] base, input int off);
    expect_win(win(base + 8'd0,  base + 8'd1,  base + 8'd4,  base + 8'd5),  off + 5,  1'b0);
    expect_win(win(base + 8'd2,  base + 8'd3,  base + 8'd6,  base + 8'd7),  off + 7,  1'b0);
    expect_win(win(base + 8'd8,  base + 8'd9,  base + 8'd12, base + 8'd13), off + 13, 1'b0);
    expect_win(win(base + 8'd10, base + 8'd11, base + 8'd14, base + 8'd15), off + 15, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic signed [7:0] mx;
    a_valid = 1'b0; a_data = '0;
    b_valid = 1'b0; b_data = '0;
    rst_n   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_valid", {31'd0, a_ovalid}, 32'd0);
    check("rst_a_data",  a_odata, 32'd0);
    check("rst_b_valid", {31'd0, b_ovalid}, 32'd0);
    check("rst_b_data",  b_odata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_all();

    // 4x4 stride 2, back-to-back
    a_cnt = 0;
    expect_frame_a(8'd0, 0);
    for (int p = 0; p < 16; p++) a_px(8'(p));
    score("s2_b2b");

    // 3x3 stride 1, overlapping windows
    b_cnt = 0;
    expect_win(win(8'd0, 8'd1, 8'd3, 8'd4), 4, 1'b0);
    expect_win(win(8'd1, 8'd2, 8'd4, 8'd5), 5, 1'b0);
    expect_win(win(8'd3, 8'd4, 8'd6, 8'd7), 7, 1'b0);
    expect_win(win(8'd4, 8'd5, 8'd7, 8'd8), 8, 1'b1);
    for (int p = 0; p < 9; p++) b_px(8'(p));
    score("s1_3x3");

    // Random idle gaps
    a_cnt = 0;
    expect_frame_a(8'd0, 0);
    for (int p = 0; p < 16; p++) begin
      a_px(8'(p));
      a_idle($urandom_range(0, 3));
    end
    score("gaps");
    a_idle(3);
    check("hold_data",  a_odata, win(8'd10, 8'd11, 8'd14, 8'd15));
    check("hold_valid", {31'd0, a_ovalid}, 32'd0);

    // Two frames back-to-back
    a_cnt = 0;
    expect_frame_a(8'd0, 0);
    expect_frame_a(8'd100, 16);
    for (int p = 0; p < 16; p++) a_px(8'(p));
    for (int p = 0; p < 16; p++) a_px(8'(100 + p));
    score("two_frames");

    // Sign bit patterns pass through, and the signed max of the first window is 0x85
    a_cnt = 0;
    expect_frame_a(8'h80, 0);
    for (int p = 0; p < 16; p++) a_px(8'(8'h80 + p));
    repeat (2) @(posedge clk);
    #1;
    mx = 8'sh7f;
    if (got_q.size() > 0) begin
      mx = got_q[0][7:0];
      for (int k = 1; k < 4; k++) begin
        if ($signed(got_q[0][k*8 +: 8]) > mx) mx = got_q[0][k*8 +: 8];
      end
    end
    check("tree_max", {24'd0, mx}, 32'h85);
    score("neg");

    // Reset mid-frame after pixel 9
    a_cnt = 0;
    for (int p = 0; p < 10; p++) a_px(8'(p));
    rst_n = 1'b0;
    #2;
    check("midrst_valid", {31'd0, a_ovalid}, 32'd0);
    check("midrst_data",  a_odata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_all();
    a_cnt = 0;
    expect_frame_a(8'd50, 0);
    for (int p = 0; p < 16; p++) a_px(8'(50 + p));
    score("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
